clint_ctrl: RTL and testbench

- Core-local interrupt/exception sequencer. Sits beside the EXE stage and is the producer of the pipeline's interrupt flush and hold.
- Watches the instruction and exception flags leaving the ID/EXE register, plus the timer interrupt line.
- Sequences the machine-mode CSR updates (mepc, mcause, mstatus), then redirects fetch with a one-cycle flush.
- Handles mret by restoring mstatus and jumping to mepc.

---
 rtl/clint_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_clint_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/clint_ctrl.sv
// -----------------------------------------------------------------------------
// clint_ctrl - core-local interrupt / exception sequencer
//
// Sits beside the EXE stage. It watches the exception flags and the
// instruction leaving ID/EXE, plus the level timer interrupt. A trap is
// handled as a fixed CSR write sequence (mepc, mcause, mstatus) followed by a
// one-cycle flush that redirects fetch. An mret restores mstatus and jumps to
// mepc.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   inst_i, inst_addr_i  instruction in EXE and its address
//   exception_i          bit0 ecall, bit1 ebreak, bit2 mret, bit3 illegal
//   irq_timer_i          level timer interrupt
//   mtvec_i, mepc_i,     current machine CSR values
//   mstatus_i, mie_i
//   csr_we_o/_waddr_o/_wdata_o   CSR write port
//   stall_o              holds IF..EXE while sequencing
//   flush_int_o          one-cycle flush with PC redirect
//   int_addr_o           redirect target (RST_PC while idle)
//
// Build option
//   CLINT_VECTORED_EN    when defined, asynchronous traps honour vectored
//                        mtvec mode (mtvec_i[1:0]==2'b01); synchronous traps
//                        always use the base address.
// -----------------------------------------------------------------------------
module clint_ctrl #(
  parameter logic [31:0] RST_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] exception_i,
  input  logic        irq_timer_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        stall_o,
  output logic        flush_int_o,
  output logic [31:0] int_addr_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEPC    = 3'd1,
    ST_MCAUSE  = 3'd2,
    ST_MSTATUS = 3'd3,
    ST_MRET    = 3'd4,
    ST_JUMP    = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_cause;
  logic [31:0] r_target;

  logic        w_sync;
  logic        w_ret;
  logic        w_async;
  logic        w_capture;
  logic [31:0] w_cause;
  logic        w_load_target;
  logic [31:0] w_target_next;
  logic        w_stall;
  logic        w_we;
  logic [11:0] w_waddr;
  logic [31:0] w_wdata;
  logic        w_flush;
  logic [31:0] w_int_addr;

  // Bits of the flag / enable words that this block never looks at.
  logic        w_unused;
  assign w_unused = ^{exception_i[31:4], mie_i[31:8], mie_i[6:0]};

  // mstatus on trap entry: MPIE <= MIE, MIE <= 0, MPP <= machine.
  function automatic logic [31:0] f_trap_mstatus(input logic [31:0] ms);
    logic [31:0] d;
    d         = ms;
    d[7]      = ms[3];
    d[3]      = 1'b0;
    d[12:11]  = 2'b11;
    return d;
  endfunction

  // mstatus on mret: MIE <= MPIE, MPIE <= 1.
  function automatic logic [31:0] f_mret_mstatus(input logic [31:0] ms);
    logic [31:0] d;
    d    = ms;
    d[3] = ms[7];
    d[7] = 1'b1;
    return d;
  endfunction

  // Lowest exception code wins when several synchronous flags are set.
  function automatic logic [31:0] f_sync_cause(input logic [31:0] ex);
    logic [31:0] c;
    if (ex[3]) begin
      c = 32'd2;
    end else if (ex[1]) begin
      c = 32'd3;
    end else begin
      c = 32'd11;
    end
    return c;
  endfunction

`ifdef CLINT_VECTORED_EN
  // Vectored mode only applies to interrupts (cause MSB set).
  function automatic logic [31:0] f_vector_target(input logic [31:0] tvec,
                                                  input logic [31:0] cause);
    logic [31:0] t;
    if ((tvec[1:0] == 2'b01) && cause[31]) begin
      t = (tvec & ~32'h3) + {cause[29:0], 2'b00};
    end else begin
      t = tvec & ~32'h3;
    end
    return t;
  endfunction
`endif

  assign w_sync  = exception_i[0] | exception_i[1] | exception_i[3];
  assign w_ret   = exception_i[2];
  // A bubble has no architectural PC to return to, so it is never interrupted.
  assign w_async = irq_timer_i & mstatus_i[3] & mie_i[7] & (inst_i != NOP_INST);

  // Next-state and output decode.
  always_comb begin
    w_next        = r_state;
    w_capture     = 1'b0;
    w_cause       = 32'h0;
    w_load_target = 1'b0;
    w_target_next = 32'h0;
    w_stall       = 1'b0;
    w_we          = 1'b0;
    w_waddr       = 12'h000;
    w_wdata       = 32'h0;
    w_flush       = 1'b0;
    w_int_addr    = RST_PC;
    case (r_state)
      ST_IDLE: begin
        if (w_sync) begin
          w_stall   = 1'b1;
          w_capture = 1'b1;
          w_cause   = f_sync_cause(exception_i);
          w_next    = ST_MEPC;
        end else if (w_ret) begin
          w_stall = 1'b1;
          w_next  = ST_MRET;
        end else if (w_async) begin
          w_stall   = 1'b1;
          w_capture = 1'b1;
          w_cause   = CAUSE_TIMER;
          w_next    = ST_MEPC;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_MEPC: begin
        w_stall = 1'b1;
        w_we    = 1'b1;
        w_waddr = CSR_MEPC;
        w_wdata = r_pc;
        w_next  = ST_MCAUSE;
      end
      ST_MCAUSE: begin
        w_stall = 1'b1;
        w_we    = 1'b1;
        w_waddr = CSR_MCAUSE;
        w_wdata = r_cause;
        w_next  = ST_MSTATUS;
      end
      ST_MSTATUS: begin
        w_stall       = 1'b1;
        w_we          = 1'b1;
        w_waddr       = CSR_MSTATUS;
        w_wdata       = f_trap_mstatus(mstatus_i);
        w_load_target = 1'b1;
`ifdef CLINT_VECTORED_EN
        w_target_next = f_vector_target(mtvec_i, r_cause);
`else
        w_target_next = mtvec_i & ~32'h3;
`endif
        w_next        = ST_JUMP;
      end
      ST_MRET: begin
        w_stall       = 1'b1;
        w_we          = 1'b1;
        w_waddr       = CSR_MSTATUS;
        w_wdata       = f_mret_mstatus(mstatus_i);
        w_load_target = 1'b1;
        w_target_next = mepc_i;
        w_next        = ST_JUMP;
      end
      ST_JUMP: begin
        w_flush    = 1'b1;
        w_int_addr = r_target;
        w_next     = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, captured trap context and redirect target.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_pc     <= 32'h0;
      r_cause  <= 32'h0;
      r_target <= RST_PC;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_pc    <= inst_addr_i;
        r_cause <= w_cause;
      end else begin
        r_pc    <= r_pc;
        r_cause <= r_cause;
      end
      if (w_load_target) begin
        r_target <= w_target_next;
      end else begin
        r_target <= r_target;
      end
    end
  end

  // The detect-cycle stall is combinational from the inputs; masking it with
  // rst_ni keeps every output quiet while reset is asserted.
  assign stall_o     = w_stall & rst_ni;
  assign csr_we_o    = w_we;
  assign csr_waddr_o = w_waddr;
  assign csr_wdata_o = w_wdata;
  assign flush_int_o = w_flush;
  assign int_addr_o  = w_int_addr;

endmodule

// File: tb/tb_clint_ctrl.sv
// Directed testbench for clint_ctrl.
module tb_clint_ctrl;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic [31:0] exception_i;
  logic        irq_timer_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic [31:0] mstatus_i;
  logic [31:0] mie_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        stall_o;
  logic        flush_int_o;
  logic [31:0] int_addr_o;

  int n_checks = 0;
  int n_errors = 0;

  clint_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .exception_i (exception_i),
    .irq_timer_i (irq_timer_i),
    .mtvec_i     (mtvec_i),
    .mepc_i      (mepc_i),
    .mstatus_i   (mstatus_i),
    .mie_i       (mie_i),
    .csr_we_o    (csr_we_o),
    .csr_waddr_o (csr_waddr_o),
    .csr_wdata_o (csr_wdata_o),
    .stall_o     (stall_o),
    .flush_int_o (flush_int_o),
    .int_addr_o  (int_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample one cycle at the falling edge, then advance past the next rising edge.
  task automatic exp_cyc(input string tag, input logic [31:0] e_stall,
                         input logic [31:0] e_we, input logic [31:0] e_addr,
                         input logic [31:0] e_data, input logic [31:0] e_flush,
                         input logic [31:0] e_target);
    @(negedge clk);
    check_val({tag, ".stall"}, {31'd0, stall_o}, e_stall);
    check_val({tag, ".we"}, {31'd0, csr_we_o}, e_we);
    check_val({tag, ".flush"}, {31'd0, flush_int_o}, e_flush);
    if (e_we != 32'd0) begin
      check_val({tag, ".waddr"}, {20'd0, csr_waddr_o}, e_addr);
      check_val({tag, ".wdata"}, csr_wdata_o, e_data);
    end
    if (e_stall == 32'd0) begin
      check_val({tag, ".int_addr"}, int_addr_o, e_target);
    end
    @(posedge clk);
    #1;
  endtask

  // Event already driven; checks T..T+4, then mimics the CSR file update.
  task automatic run_trap(input string tag, input logic [31:0] pc,
                          input logic [31:0] cause, input logic [31:0] ms,
                          input logic [31:0] tgt);
    exp_cyc({tag, ".T"}, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    exception_i = 32'h0;
    exp_cyc({tag, ".mepc"}, 32'd1, 32'd1, 32'h341, pc, 32'd0, 32'd0);
    exp_cyc({tag, ".mcause"}, 32'd1, 32'd1, 32'h342, cause, 32'd0, 32'd0);
    exp_cyc({tag, ".mstatus"}, 32'd1, 32'd1, 32'h300, ms, 32'd0, 32'd0);
    exp_cyc({tag, ".jump"}, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, tgt);
    mstatus_i = ms;
    mepc_i    = pc;
  endtask

  task automatic run_mret(input string tag, input logic [31:0] ms,
                          input logic [31:0] tgt);
    exp_cyc({tag, ".T"}, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    exception_i = 32'h0;
    exp_cyc({tag, ".mstatus"}, 32'd1, 32'd1, 32'h300, ms, 32'd0, 32'd0);
    exp_cyc({tag, ".jump"}, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, tgt);
    mstatus_i = ms;
  endtask

  task automatic idle_cyc(input string tag);
    exp_cyc(tag, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    inst_i      = ADDI;
    inst_addr_i = 32'h0;
    exception_i = 32'h0;
    irq_timer_i = 1'b0;
    mtvec_i     = 32'h200;
    mepc_i      = 32'h0;
    mstatus_i   = 32'h0;
    mie_i       = 32'h0;
    #12;
    check_val("rst.stall", {31'd0, stall_o}, 32'd0);
    check_val("rst.we", {31'd0, csr_we_o}, 32'd0);
    check_val("rst.waddr", {20'd0, csr_waddr_o}, 32'd0);
    check_val("rst.wdata", csr_wdata_o, 32'd0);
    check_val("rst.flush", {31'd0, flush_int_o}, 32'd0);
    check_val("rst.int_addr", int_addr_o, 32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cyc("idle0");

    // ecall at 0x100
    mstatus_i = 32'h8; inst_addr_i = 32'h100; exception_i = 32'h1;
    run_trap("ecall", 32'h100, 32'd11, 32'h1880, 32'h200);
    idle_cyc("ecall.idle");

    // Timer interrupt on a real instruction
    mstatus_i = 32'h8; mie_i = 32'h80; irq_timer_i = 1'b1; inst_addr_i = 32'h40;
    run_trap("irq", 32'h40, 32'h8000_0007, 32'h1880, 32'h200);
    idle_cyc("irq.masked");

    // Bubble blocks the interrupt until a real instruction arrives
    mstatus_i = 32'h8; inst_i = NOP;
    idle_cyc("nop0");
    idle_cyc("nop1");
    inst_i = ADDI; inst_addr_i = 32'h44;
    run_trap("irq_after_nop", 32'h44, 32'h8000_0007, 32'h1880, 32'h200);
    irq_timer_i = 1'b0;

    // mret
    mstatus_i = 32'h1880; mepc_i = 32'h104; exception_i = 32'h4;
    run_mret("mret", 32'h1888, 32'h104);
    idle_cyc("mret.idle");

    // Unused flag bits are ignored
    exception_i = 32'hFFFF_FFF0;
    idle_cyc("ex_hi_bits");
    exception_i = 32'h0;

    // All flags: sync beats ret, illegal has the lowest code
    mstatus_i = 32'h8; inst_addr_i = 32'h60; exception_i = 32'hF;
    run_trap("all_flags", 32'h60, 32'd2, 32'h1880, 32'h200);

    // ebreak and irq together: ebreak first, irq only after mret
    mstatus_i = 32'h8; mie_i = 32'h80; irq_timer_i = 1'b1;
    inst_addr_i = 32'h80; exception_i = 32'h2;
    run_trap("ebreak_irq", 32'h80, 32'd3, 32'h1880, 32'h200);
    idle_cyc("pend0");
    idle_cyc("pend1");
    inst_addr_i = 32'h84; exception_i = 32'h4;
    run_mret("mret2", 32'h1888, 32'h80);
    run_trap("irq_pending", 32'h84, 32'h8000_0007, 32'h1880, 32'h200);
    irq_timer_i = 1'b0;

    // Reset during S_MCAUSE
    mstatus_i = 32'h8; inst_addr_i = 32'h90; exception_i = 32'h1;
    exp_cyc("rstseq.T", 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    exception_i = 32'h0;
    exp_cyc("rstseq.mepc", 32'd1, 32'd1, 32'h341, 32'h90, 32'd0, 32'd0);
    rst_n = 1'b0;
    #1;
    check_val("rstseq.stall", {31'd0, stall_o}, 32'd0);
    check_val("rstseq.we", {31'd0, csr_we_o}, 32'd0);
    check_val("rstseq.flush", {31'd0, flush_int_o}, 32'd0);
    check_val("rstseq.int_addr", int_addr_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cyc("rstseq.after0");
    idle_cyc("rstseq.after1");
    idle_cyc("rstseq.after2");

    // Vectored mtvec: only the timer interrupt is vectored, and only when enabled
    mtvec_i = 32'h201; mstatus_i = 32'h8; mie_i = 32'h80; irq_timer_i = 1'b1;
    inst_addr_i = 32'h48;
`ifdef CLINT_VECTORED_EN
    run_trap("vec_irq", 32'h48, 32'h8000_0007, 32'h1880, 32'h21C);
`else
    run_trap("vec_irq", 32'h48, 32'h8000_0007, 32'h1880, 32'h200);
`endif
    irq_timer_i = 1'b0;
    mstatus_i = 32'h8; inst_addr_i = 32'h4C; exception_i = 32'h1;
    run_trap("vec_ecall", 32'h4C, 32'd11, 32'h1880, 32'h200);
    idle_cyc("end.idle");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
